fir_coef_bank_ctrl: RTL and testbench
=====================================

// Module: fir_coef_bank_ctrl
// PURPOSE
//  Coefficient configuration controller for the 16-tap symmetric parallel FIR (8 unique 12-bit taps).
//  Holds an active and a shadow coefficient bank. Takes tap writes through a valid/ready port.
//  Swaps banks atomically on a sample boundary, optionally clears the FIR delay line, and gates the
//  FIR output-valid flag until the filter has settled on the new coefficient set.
// PARAMETERS
//  NCOEF     8  unique symmetric taps (filter length 2*NCOEF)
//  CW        12 coefficient width, signed two's complement
//  LATENCY   4  FIR pipeline depth in sample_en strobes (delay line, pre-add, mult, sum)
//  FLUSH_ON_SWAP 1  1: pulse fir_clr at swap; 0: no clear, only output gating
// PORTS
//  clk        in  1        system clock
//  rst        in  1        reset, asynchronous, active-high
//  sample_en  in  1        one-cycle strobe: FIR advances one sample this cycle
//  cfg_valid  in  1        tap write request
//  cfg_ready  out 1        controller accepts tap write
//  cfg_addr   in  3        tap index 0..NCOEF-1
//  cfg_data   in  CW       tap value
//  cfg_last   in  1        marks final write of a set; requests commit
//  coe_flat   out NCOEF*CW active bank; tap k at [k*CW +: CW], registered
//  fir_clr    out 1        one-cycle FIR delay-line clear
//  yout_valid out 1        FIR output word valid this cycle
//  bank_sel   out 1        index of active bank; toggles on every swap
//  cfg_err    out 1        one-cycle pulse: incomplete set committed
//  busy       out 1        high in ARMED or SETTLE
// BEHAVIOUR
//  Reset values:
//   - Active bank = DEFAULT_COEF (package). Shadow bank = 0.
//   - bank_sel=0. cfg_ready=1. All pulses, yout_valid and busy = 0. State = IDLE.
//   - Written-mask = 0. Settle count = 0.
//  Write handshake:
//   - A write is accepted on a cycle with cfg_valid & cfg_ready. It writes shadow[cfg_addr] and sets mask bit cfg_addr.
//   - Writing the same address twice: the last write wins.
//   - cfg_addr >= NCOEF is accepted but ignored; it also counts toward no mask bit.
//  FSM:
//   - IDLE: cfg_ready=1. On an accepted write go to LOAD. If that write has cfg_last, treat it as in LOAD.
//   - LOAD: cfg_ready=1.
//     - Accepted write with cfg_last and full mask (all NCOEF bits set, including this write) -> ARMED.
//     - Accepted write with cfg_last and incomplete mask -> cfg_err pulse next cycle, mask cleared, IDLE.
//       The shadow contents are kept.
//   - ARMED: cfg_ready=0. On sample_en -> swap.
//     - Next cycle: coe_flat shows the new bank, bank_sel toggles, fir_clr=1 if FLUSH_ON_SWAP.
//     - Mask cleared, go to SETTLE.
//   - SETTLE: cfg_ready=0. Count sample_en strobes from 0.
//     - Leave for IDLE when the count reaches 2*NCOEF+LATENCY-1 (=19).
//     - The counter is 5 bits wide and saturates; it never wraps.
//  Output valid:
//   - yout_valid = sample_en delayed LATENCY clock cycles (shift register).
//   - yout_valid is forced to 0 while in SETTLE, and on the swap cycle.
//  Boundary cases:
//   - sample_en on the same cycle as the completing cfg_last write: the swap waits for the next sample_en.
//   - cfg_valid held while cfg_ready=0: no write; the data is held by the requester.
//   - Reset mid-LOAD or mid-SETTLE: shadow discarded, active bank returns to DEFAULT_COEF, bank_sel=0.
//  Arithmetic: none. This is a pure storage and sequencing block.
// STRUCTURE
//  Package fir_cfg_pkg:
//   - NCOEF, CW
//   - DEFAULT_COEF[0:7] = 000, FFD, 00F, 02E, F8B, EF9, 24E, 7FF (hex)
//   - state enum {IDLE, LOAD, ARMED, SETTLE}
//  One sub-module, fir_coef_bank:
//   - Dual bank register file, shadow write port, swap input, flattened active output.
//  Top level holds: FSM, mask, settle counter, valid delay line.
// TESTING
//  - Reset check: coe_flat = DEFAULT_COEF, bank_sel=0, cfg_ready=1, yout_valid=0 across 10 sample_en.
//    After reset release, yout_valid rises exactly 4 cycles after the first sample_en.
//  - Full load: write taps 0..7 = 001..008, cfg_last on tap 7, then sample_en.
//    Required: coe_flat[11:0]=001 and [95:84]=008 one cycle later, fir_clr single pulse, bank_sel=1.
//    yout_valid stays 0 for the next 19 sample_en strobes.
//  - Incomplete set: write taps 0..5 with cfg_last on tap 5.
//    Required: cfg_err single pulse, state IDLE, coe_flat unchanged, no fir_clr.
//  - Backpressure: cfg_valid held in ARMED and SETTLE.
//    Required: cfg_ready=0, shadow unchanged. The write lands the first cycle after returning to IDLE.
//  - Duplicate write: tap 3 written A5A then 123 within one set.
//    Required: after swap, tap 3 = 123, no cfg_err.
//  - Reset mid-SETTLE: after the 5th sample_en, assert rst.
//    Required: DEFAULT_COEF restored, bank_sel=0, busy=0, cfg_ready=1.

Source files
------------

// File: rtl/fir_cfg_pkg.sv
// Shared constants and types for the FIR coefficient configuration controller.
// Defines the reset coefficient set, tap-bank layout and controller state encoding.
package fir_cfg_pkg;

  localparam int unsigned NCOEF = 8;
  localparam int unsigned CW    = 12;
  localparam int unsigned AW    = 3;

  typedef logic [CW-1:0]            coef_t;
  typedef logic [NCOEF-1:0][CW-1:0] coef_bank_t;

  // Tap k sits in element [k], so the packed bank flattens with tap k at [k*CW +: CW].
  localparam coef_bank_t DEFAULT_COEF = {
    12'h7FF, 12'h24E, 12'hEF9, 12'hF8B,
    12'h02E, 12'h00F, 12'hFFD, 12'h000
  };

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_ARMED  = 2'd2,
    ST_SETTLE = 2'd3
  } state_e;

  // One-hot tap select; out-of-range addresses select nothing.
  function automatic logic [NCOEF-1:0] addr_mask(input logic [AW-1:0] addr);
    addr_mask = '0;
    if (32'(addr) < NCOEF) addr_mask[addr] = 1'b1;
  endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Active/shadow coefficient register pair. Writes go to the shadow bank; a swap
// exchanges the banks in one cycle so the FIR never sees a partially updated set.
module fir_coef_bank
  import fir_cfg_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en_i,
  input  logic [AW-1:0]         wr_addr_i,
  input  logic [CW-1:0]         wr_data_i,
  input  logic                  swap_i,
  output logic [NCOEF*CW-1:0]   coe_flat_o
);

  coef_bank_t active_q;
  coef_bank_t shadow_q;
  logic       wr_hit;

  assign wr_hit = wr_en_i && (|addr_mask(wr_addr_i));

  // Swapping exchanges rather than copies, so the retired set becomes the new shadow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= DEFAULT_COEF;
      shadow_q <= '0;
    end else if (swap_i) begin
      active_q <= shadow_q;
      shadow_q <= active_q;
    end else if (wr_hit) begin
      shadow_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign coe_flat_o = active_q;

endmodule

// File: rtl/fir_coef_bank_ctrl.sv
// Coefficient configuration controller: collects tap writes into the shadow bank,
// swaps banks on a sample boundary and suppresses FIR output until it has settled.
module fir_coef_bank_ctrl
  import fir_cfg_pkg::*;
#(
  parameter int unsigned LATENCY       = 4,
  parameter bit          FLUSH_ON_SWAP = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_en,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [AW-1:0]       cfg_addr,
  input  logic [CW-1:0]       cfg_data,
  input  logic                cfg_last,
  output logic [NCOEF*CW-1:0] coe_flat,
  output logic                fir_clr,
  output logic                yout_valid,
  output logic                bank_sel,
  output logic                cfg_err,
  output logic                busy
);

  localparam logic [4:0] SETTLE_LAST = 5'(2*NCOEF + LATENCY - 1);

  state_e             state_q, state_d;
  logic [NCOEF-1:0]   mask_q, mask_d;
  logic [NCOEF-1:0]   mask_wr;
  logic [4:0]         cnt_q, cnt_d;
  logic [LATENCY-1:0] vld_q;
  logic               err_q, err_d;
  logic               clr_q;
  logic               sel_q;
  logic               wr_acc;
  logic               swap;

  assign cfg_ready = (state_q == ST_IDLE) || (state_q == ST_LOAD);
  assign busy      = (state_q == ST_ARMED) || (state_q == ST_SETTLE);
  assign wr_acc    = cfg_valid && cfg_ready;
  assign swap      = (state_q == ST_ARMED) && sample_en;
  assign mask_wr   = mask_q | addr_mask(cfg_addr);

  // A cfg_last write arriving in IDLE is judged exactly as if it came in LOAD.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE, ST_LOAD: begin
        if (wr_acc) begin
          mask_d  = mask_wr;
          state_d = ST_LOAD;
          if (cfg_last) begin
            if (&mask_wr) begin
              state_d = ST_ARMED;
            end else begin
              err_d   = 1'b1;
              mask_d  = '0;
              state_d = ST_IDLE;
            end
          end
        end
      end
      ST_ARMED: begin
        if (sample_en) begin
          mask_d  = '0;
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (sample_en && (cnt_q != '1)) cnt_d = cnt_q + 5'd1;
        if (cnt_d >= SETTLE_LAST) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      clr_q   <= 1'b0;
      sel_q   <= 1'b0;
      vld_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      clr_q   <= swap && FLUSH_ON_SWAP;
      if (swap) sel_q <= ~sel_q;
      vld_q   <= {vld_q[LATENCY-2:0], sample_en};
    end
  end

  fir_coef_bank u_bank (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (wr_acc),
    .wr_addr_i  (cfg_addr),
    .wr_data_i  (cfg_data),
    .swap_i     (swap),
    .coe_flat_o (coe_flat)
  );

  assign fir_clr    = clr_q;
  assign cfg_err    = err_q;
  assign bank_sel   = sel_q;
  assign yout_valid = vld_q[LATENCY-1] && (state_q != ST_SETTLE) && !swap;

endmodule

// File: tb/tb_fir_coef_bank_ctrl.sv
// Bench for fir_coef_bank_ctrl: a transaction-level model checked every cycle,
// plus literal expectations for each directed scenario.
module tb_fir_coef_bank_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_en;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [2:0]  cfg_addr;
  logic [11:0] cfg_data;
  logic        cfg_last;
  logic [95:0] coe_flat;
  logic        fir_clr;
  logic        yout_valid;
  logic        bank_sel;
  logic        cfg_err;
  logic        busy;

  always #5 clk = ~clk;

  fir_coef_bank_ctrl #(.LATENCY(4), .FLUSH_ON_SWAP(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .sample_en  (sample_en),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .cfg_last   (cfg_last),
    .coe_flat   (coe_flat),
    .fir_clr    (fir_clr),
    .yout_valid (yout_valid),
    .bank_sel   (bank_sel),
    .cfg_err    (cfg_err),
    .busy       (busy)
  );

  localparam logic [95:0] DEF_FLAT = 96'h7FF_24E_EF9_F8B_02E_00F_FFD_000;

  int total = 0;
  int bad   = 0;

  // Model: phase 0=idle, 1=loading, 2=armed, 3=settling.
  logic [11:0] m_def [8] = '{12'h000, 12'hFFD, 12'h00F, 12'h02E,
                             12'hF8B, 12'hEF9, 12'h24E, 12'h7FF};
  logic [11:0] m_act [8];
  logic [11:0] m_shd [8];
  bit          m_wr  [8];
  bit          m_h   [4];
  int          m_ph;
  int          m_cnt;
  bit          m_sel, m_clr, m_err;

  task automatic check(input string nm, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    check(nm, {95'd0, act}, {95'd0, exp});
  endtask

  function automatic logic [11:0] tap(input int k);
    return coe_flat[k*12 +: 12];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 8; k++) begin
      m_act[k] = m_def[k];
      m_shd[k] = 12'h000;
      m_wr[k]  = 1'b0;
    end
    for (int k = 0; k < 4; k++) m_h[k] = 1'b0;
    m_ph = 0; m_cnt = 0; m_sel = 1'b0; m_clr = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_step();
    logic [95:0] f;
    logic [11:0] t;
    bit          all;
    if (rst) model_reset();
    for (int k = 0; k < 8; k++) f[k*12 +: 12] = m_act[k];
    check("coe_flat", coe_flat, f);
    chkb("bank_sel", bank_sel, m_sel);
    chkb("cfg_ready", cfg_ready, m_ph < 2);
    chkb("busy", busy, m_ph >= 2);
    chkb("fir_clr", fir_clr, m_clr);
    chkb("cfg_err", cfg_err, m_err);
    chkb("yout_valid", yout_valid, m_h[3] && (m_ph != 3) && !(m_ph == 2 && sample_en));
    if (!rst) begin
      m_clr = 1'b0;
      m_err = 1'b0;
      if (cfg_valid && m_ph < 2) begin
        if (int'(cfg_addr) < 8) begin
          m_shd[cfg_addr] = cfg_data;
          m_wr[cfg_addr]  = 1'b1;
        end
        if (cfg_last) begin
          all = 1'b1;
          for (int k = 0; k < 8; k++) all = all && m_wr[k];
          if (all) m_ph = 2;
          else begin
            m_err = 1'b1;
            for (int k = 0; k < 8; k++) m_wr[k] = 1'b0;
            m_ph = 0;
          end
        end else m_ph = 1;
      end else if (m_ph == 2 && sample_en) begin
        for (int k = 0; k < 8; k++) begin
          t = m_act[k]; m_act[k] = m_shd[k]; m_shd[k] = t; m_wr[k] = 1'b0;
        end
        m_sel = !m_sel; m_clr = 1'b1; m_ph = 3; m_cnt = 0;
      end else if (m_ph == 3 && sample_en) begin
        m_cnt++;
        if (m_cnt >= 19) m_ph = 0;
      end
      m_h[3] = m_h[2]; m_h[2] = m_h[1]; m_h[1] = m_h[0]; m_h[0] = sample_en;
    end
  endtask

  // Inputs change 2 time units after a rising edge; the model compares on the falling edge.
  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [2:0] a, input logic [11:0] d, input logic l);
    cfg_valid = 1'b1; cfg_addr = a; cfg_data = d; cfg_last = l;
    tick();
    cfg_valid = 1'b0; cfg_last = 1'b0;
  endtask

  task automatic strobe();
    sample_en = 1'b1; tick(); sample_en = 1'b0;
  endtask

  task automatic settle_run();
    for (int k = 1; k <= 19; k++) begin
      strobe();
      chkb("settle_yout", yout_valid, 1'b0);
      chkb("settle_busy", busy, k < 19);
      tick();
    end
  endtask

  initial begin
    logic [95:0] e;
    rst = 1'b1; sample_en = 1'b0; cfg_valid = 1'b0; cfg_last = 1'b0;
    cfg_addr = '0; cfg_data = '0;
    model_reset();

    // Reset state held across 10 strobes
    for (int i = 0; i < 10; i++) begin
      strobe();
      chkb("rst_yout", yout_valid, 1'b0);
      tick();
    end
    check("rst_coe", coe_flat, DEF_FLAT);
    chkb("rst_sel", bank_sel, 1'b0);
    chkb("rst_ready", cfg_ready, 1'b1);
    chkb("rst_busy", busy, 1'b0);
    rst = 1'b0;
    tick(); tick();
    strobe();
    tick(); tick();
    chkb("lat_c3", yout_valid, 1'b0);
    tick();
    chkb("lat_c4", yout_valid, 1'b1);
    tick();
    chkb("lat_c5", yout_valid, 1'b0);

    // Full load 001..008 then swap
    for (int i = 0; i < 8; i++) wr(3'(i), 12'(i + 1), i == 7);
    chkb("armed_busy", busy, 1'b1);
    chkb("armed_ready", cfg_ready, 1'b0);
    check("armed_coe", coe_flat, DEF_FLAT);
    strobe();
    check("load_tap0", {84'd0, tap(0)}, 96'h001);
    check("load_tap7", {84'd0, tap(7)}, 96'h008);
    chkb("load_clr", fir_clr, 1'b1);
    chkb("load_sel", bank_sel, 1'b1);
    tick();
    chkb("load_clr_end", fir_clr, 1'b0);
    settle_run();

    // Incomplete set: taps 0..5 only
    for (int i = 0; i < 8; i++) e[i*12 +: 12] = 12'(i + 1);
    for (int i = 0; i < 6; i++) wr(3'(i), 12'h0F0 + 12'(i), i == 5);
    chkb("inc_err", cfg_err, 1'b1);
    chkb("inc_busy", busy, 1'b0);
    chkb("inc_ready", cfg_ready, 1'b1);
    chkb("inc_clr", fir_clr, 1'b0);
    check("inc_coe", coe_flat, e);
    tick();
    chkb("inc_err_end", cfg_err, 1'b0);

    // Duplicate write to tap 3, then backpressure through ARMED and SETTLE
    wr(3'd0, 12'h010, 1'b0);
    wr(3'd3, 12'hA5A, 1'b0);
    wr(3'd1, 12'h011, 1'b0);
    wr(3'd2, 12'h012, 1'b0);
    wr(3'd3, 12'h123, 1'b0);
    wr(3'd4, 12'h014, 1'b0);
    wr(3'd5, 12'h015, 1'b0);
    wr(3'd6, 12'h016, 1'b0);
    wr(3'd7, 12'h017, 1'b1);
    chkb("dup_err", cfg_err, 1'b0);
    chkb("dup_busy", busy, 1'b1);
    cfg_valid = 1'b1; cfg_addr = 3'd2; cfg_data = 12'h777; cfg_last = 1'b0;
    tick(); tick(); tick();
    chkb("bp_ready", cfg_ready, 1'b0);
    strobe();
    check("dup_tap3", {84'd0, tap(3)}, 96'h123);
    check("bp_tap2", {84'd0, tap(2)}, 96'h012);
    chkb("bp_sel", bank_sel, 1'b0);
    tick();
    settle_run();
    tick();
    cfg_valid = 1'b0;
    chkb("bp_land_busy", busy, 1'b0);
    chkb("bp_land_ready", cfg_ready, 1'b1);
    for (int i = 0; i < 8; i++)
      if (i != 2) wr(3'(i), 12'h100 + 12'(i), i == 7);
    chkb("bp_armed", busy, 1'b1);
    strobe();
    check("bp_land_tap2", {84'd0, tap(2)}, 96'h777);
    check("bp_land_tap0", {84'd0, tap(0)}, 96'h100);
    check("bp_land_tap7", {84'd0, tap(7)}, 96'h107);
    chkb("bp_land_sel", bank_sel, 1'b1);
    tick();
    settle_run();

    // Completing write coincides with sample_en; swap waits for the next strobe
    for (int i = 0; i < 7; i++) wr(3'(i), 12'h200 + 12'(i), 1'b0);
    sample_en = 1'b1;
    wr(3'd7, 12'h207, 1'b1);
    sample_en = 1'b0;
    chkb("same_busy", busy, 1'b1);
    chkb("same_sel", bank_sel, 1'b1);
    check("same_tap0", {84'd0, tap(0)}, 96'h100);
    strobe();
    chkb("same_sel_swap", bank_sel, 1'b0);
    check("same_tap0_swap", {84'd0, tap(0)}, 96'h200);
    tick();

    // Reset after the 5th strobe of SETTLE
    for (int i = 0; i < 5; i++) begin
      strobe();
      tick();
    end
    chkb("mid_busy", busy, 1'b1);
    rst = 1'b1;
    tick();
    check("mid_rst_coe", coe_flat, DEF_FLAT);
    chkb("mid_rst_sel", bank_sel, 1'b0);
    chkb("mid_rst_busy", busy, 1'b0);
    chkb("mid_rst_ready", cfg_ready, 1'b1);
    chkb("mid_rst_clr", fir_clr, 1'b0);
    rst = 1'b0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
